// File: rtl/fc_pkg.sv
// Shared constants and types for the fast-cluster word feeder.
package fc_pkg;

   localparam int FC_WORD_W = 16;

   localparam logic [1:0] FC_RUN   = 2'b11;
   localparam logic [1:0] FC_FLUSH = 2'b00;

   localparam logic [FC_WORD_W-1:0] FC_SYNC_WORD = 16'hBC5C;
   localparam logic [FC_WORD_W-1:0] FC_IDLE_WORD = 16'hFFFF;

   typedef enum logic [1:0] {
      SEL_SYNC = 2'd0,
      SEL_HEAD = 2'd1,
      SEL_IDLE = 2'd2
   } fc_sel_t;

endpackage

// File: rtl/fc_sync_fifo.sv
// Single-clock word FIFO with synchronous flush; a push into a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module fc_sync_fifo
   import fc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [FC_WORD_W-1:0]    wr_data,
   output logic [FC_WORD_W-1:0]    head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int PW = $clog2(DEPTH);

   logic [FC_WORD_W-1:0] mem_reg [DEPTH];
   logic [PW-1:0]        wr_ptr_reg;
   logic [PW-1:0]        rd_ptr_reg;
   logic [PW:0]          level_reg;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (level_reg == (PW+1)'(DEPTH));
   assign empty   = (level_reg == '0);
   assign level   = level_reg;
   assign head    = mem_reg[rd_ptr_reg];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push && !srst && !flush) mem_reg[wr_ptr_reg] <= wr_data;
   end

endmodule

// File: rtl/fc_word_feeder.sv
// Feeds the fast-cluster serializer: queued words, periodic SYNC, IDLE fill.
module fc_word_feeder
   import fc_pkg::*;
#(
   parameter int                   DEPTH       = 8,
   parameter int                   SYNC_PERIOD = 32,
   parameter logic [FC_WORD_W-1:0] SYNC_WORD   = FC_SYNC_WORD,
   parameter logic [FC_WORD_W-1:0] IDLE_WORD   = FC_IDLE_WORD
) (
   input  logic                    FSclk,
   input  logic                    reset,
   input  logic [1:0]              control,
   input  logic                    serializing,
   input  logic                    wr_en,
   input  logic [FC_WORD_W-1:0]    wr_data,
   output logic [FC_WORD_W-1:0]    data_out,
   output logic                    load_strobe,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow
);

   localparam int              LC_W    = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
   localparam logic [LC_W-1:0] LC_LAST = (SYNC_PERIOD > 1) ? LC_W'(SYNC_PERIOD - 1) : '0;

   logic [LC_W-1:0]      lc_reg;
   logic                 overflow_reg;
   logic [FC_WORD_W-1:0] head;
   fc_sel_t              sel;
   logic                 load;
   logic                 flush;
   logic                 push;
   logic                 pop;
   logic                 sync_due;

   assign load        = (control == FC_RUN) && !serializing;
   assign flush       = (control == FC_FLUSH);
   assign push        = wr_en && !flush;
   assign load_strobe = load;
   assign overflow    = overflow_reg;
   assign sync_due    = (SYNC_PERIOD != 0) && (lc_reg == '0);
   assign pop         = load && (sel == SEL_HEAD);

   // Selection depends only on registered state, so data_out is stable
   // between load edges apart from a write into an empty FIFO or a flush.
   always_comb begin
      sel = SEL_IDLE;
      if (sync_due)    sel = SEL_SYNC;
      else if (!empty) sel = SEL_HEAD;
   end

   always_comb begin
      data_out = IDLE_WORD;
      case (sel)
         SEL_SYNC: data_out = SYNC_WORD;
         SEL_HEAD: data_out = head;
         default:  data_out = IDLE_WORD;
      endcase
   end

   fc_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (FSclk),
      .srst    (reset),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_data),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   always_ff @(posedge FSclk) begin
      if (reset || flush) begin
         lc_reg <= '0;
      end else if (load) begin
         lc_reg <= (SYNC_PERIOD == 0 || lc_reg == LC_LAST) ? '0 : lc_reg + 1'b1;
      end
   end

   // Sticky: a flush never clears it, only reset does.
   always_ff @(posedge FSclk) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else if (push && full && !pop) begin
         overflow_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fc_word_feeder.sv
// Directed bench for fc_word_feeder: default instance plus a SYNC_PERIOD=4 instance.
module tb_fc_word_feeder;
   import fc_pkg::*;

   logic        FSclk = 1'b0;
   logic        reset;
   logic [1:0]  control,  control4;
   logic        serializing, serializing4;
   logic        wr_en, wr_en4;
   logic [15:0] wr_data, wr_data4;
   logic [15:0] data_out, data_out4;
   logic        load_strobe, load_strobe4;
   logic        full, full4, empty, empty4, overflow, overflow4;
   logic [3:0]  fifo_level, fifo_level4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 FSclk = ~FSclk;

   fc_word_feeder dut (
      .FSclk(FSclk), .reset(reset), .control(control), .serializing(serializing),
      .wr_en(wr_en), .wr_data(wr_data), .data_out(data_out), .load_strobe(load_strobe),
      .full(full), .empty(empty), .fifo_level(fifo_level), .overflow(overflow)
   );

   fc_word_feeder #(.SYNC_PERIOD(4)) dut4 (
      .FSclk(FSclk), .reset(reset), .control(control4), .serializing(serializing4),
      .wr_en(wr_en4), .wr_data(wr_data4), .data_out(data_out4), .load_strobe(load_strobe4),
      .full(full4), .empty(empty4), .fifo_level(fifo_level4), .overflow(overflow4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge FSclk);
      #1;
   endtask

   // One serializer load on the default instance, then leave it busy.
   task automatic do_load(input string tag, input logic [15:0] exp);
      serializing = 1'b0;
      #1;
      check({tag, "_strobe"}, 32'(load_strobe), 32'd1);
      check(tag, 32'(data_out), 32'(exp));
      step(1);
      serializing = 1'b1;
   endtask

   task automatic write_word(input logic [15:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step(1);
      wr_en   = 1'b0;
   endtask

   logic [15:0] seq4 [8];

   initial begin
      seq4 = '{16'hBC5C, 16'h0001, 16'h0002, 16'h0003, 16'hBC5C, 16'h0004, 16'h0005, 16'h0006};
      reset = 1'b1; control = FC_RUN; serializing = 1'b1; wr_en = 1'b0; wr_data = '0;
      control4 = 2'b01; serializing4 = 1'b1; wr_en4 = 1'b0; wr_data4 = '0;
      step(2);
      reset = 1'b0;
      #1;
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_data_out", 32'(data_out), 32'hBC5C);

      // SYNC first, then IDLE fill every 16 cycles
      do_load("load_sync", 16'hBC5C);
      step(7);
      check("busy_strobe", 32'(load_strobe), 32'd0);
      step(8);
      do_load("load_idle1", 16'hFFFF);
      step(15);
      do_load("load_idle2", 16'hFFFF);

      write_word(16'h1234);
      write_word(16'hABCD);
      #1;
      check("two_level", 32'(fifo_level), 32'd2);
      do_load("load_1234", 16'h1234);
      check("pop1_level", 32'(fifo_level), 32'd1);
      step(3);
      do_load("load_abcd", 16'hABCD);
      check("pop2_level", 32'(fifo_level), 32'd0);
      check("drain_idle", 32'(data_out), 32'hFFFF);

      // fill in hold, ninth word dropped
      control = 2'b01;
      for (int i = 0; i < 9; i++) write_word(16'h0100 + 16'(i));
      #1;
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_level", 32'(fifo_level), 32'd8);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("hold_strobe", 32'(load_strobe), 32'd0);
      control = FC_RUN;
      wr_en = 1'b1; wr_data = 16'h2000;
      do_load("full_pushpop", 16'h0100);
      wr_en = 1'b0;
      #1;
      check("pushpop_level", 32'(fifo_level), 32'd8);
      check("pushpop_ovf", 32'(overflow), 32'd1);
      do_load("after_full", 16'h0101);

      // flush clears FIFO and lc, keeps overflow, ignores the write
      control = FC_FLUSH; wr_en = 1'b1; wr_data = 16'hDEAD;
      step(1);
      control = FC_RUN; wr_en = 1'b0;
      #1;
      check("flush_level", 32'(fifo_level), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_ovf", 32'(overflow), 32'd1);
      do_load("flush_sync", 16'hBC5C);

      // write into empty FIFO on a load edge with lc != 0
      wr_en = 1'b1; wr_data = 16'h5A5A;
      do_load("same_edge_idle", 16'hFFFF);
      wr_en = 1'b0;
      #1;
      check("same_edge_level", 32'(fifo_level), 32'd1);
      check("same_edge_head", 32'(data_out), 32'h5A5A);
      do_load("same_edge_next", 16'h5A5A);

      // hold still accepts writes
      control = 2'b01; serializing = 1'b0;
      write_word(16'h7777);
      check("hold_write_level", 32'(fifo_level), 32'd1);
      serializing = 1'b1;

      // mid-stream reset
      reset = 1'b1;
      step(1);
      reset = 1'b0; control = FC_RUN;
      #1;
      check("rst2_level", 32'(fifo_level), 32'd0);
      check("rst2_overflow", 32'(overflow), 32'd0);
      do_load("rst2_sync", 16'hBC5C);

      // SYNC_PERIOD=4 instance, kept non-empty
      for (int i = 1; i <= 6; i++) begin
         wr_en4 = 1'b1; wr_data4 = 16'(i);
         step(1);
      end
      wr_en4 = 1'b0;
      control4 = FC_RUN; serializing4 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("sp4_load%0d", i), 32'(data_out4), 32'(seq4[i]));
         step(1);
      end
      serializing4 = 1'b1;
      #1;
      check("sp4_empty", 32'(empty4), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
